// File: rtl/scan_belief_mem_if.sv
// Write/read/clear bundle between the B-update PE array, the belief store and
// the LLR PE input mux.
interface scan_belief_mem_if #(
    parameter int P    = 128,
    parameter int Q    = 6,
    parameter int N    = 1024,
    parameter int LOGN = $clog2(N),
    parameter int LW   = $clog2(LOGN),
    parameter int AW   = ((LOGN - 1 - $clog2(P)) > 1) ? (LOGN - 1 - $clog2(P)) : 1
);
    logic                clr_start;
    logic                busy;
    logic                w_en;
    logic [LW-1:0]       w_layer;
    logic [AW-1:0]       w_addr;
    logic [2*P*Q-1:0]    b_in;
    logic                r_en;
    logic [LW-1:0]       r_layer;
    logic [AW-1:0]       r_addr;
    logic [P*Q-1:0]      b_out;
    logic                r_valid;

    modport master (
        output clr_start, w_en, w_layer, w_addr, b_in, r_en, r_layer, r_addr,
        input  busy, b_out, r_valid
    );

    modport slave (
        input  clr_start, w_en, w_layer, w_addr, b_in, r_en, r_layer, r_addr,
        output busy, b_out, r_valid
    );
endinterface

// File: rtl/scan_belief_mem.sv
// Per-layer SCAN B (partial-sum belief) store for layers 1..LOGN-1 with registered
// read, write-to-read bypass and a one-layer-per-cycle clear sequencer.
module scan_belief_mem #(
    parameter int P    = 128,
    parameter int Q    = 6,
    parameter int N    = 1024,
    parameter int LOGN = $clog2(N),
    parameter int LW   = $clog2(LOGN),
    parameter int AW   = ((LOGN - 1 - $clog2(P)) > 1) ? (LOGN - 1 - $clog2(P)) : 1
) (
    input  logic              clk,
    input  logic              rst,
    scan_belief_mem_if.slave  bus
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           busy;
    logic           wr_ok;
    logic [P*Q-1:0] b_out_q, b_out_d;
    logic           r_valid_q, r_valid_d;
    logic [P*Q-1:0] rd_data [LOGN];

    assign busy  = (state_q == CLEAR);
    assign wr_ok = bus.w_en && !busy;

    // Clear sequencer: cnt walks layers 1..LOGN-1, one per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = LW'(1);
                end
            end
            CLEAR: begin
                if (cnt_q == LW'(LOGN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rd_data[0] = '0;

    for (genvar l = 1; l < LOGN; l++) begin : g_layer
        localparam int S  = 1 << l;
        localparam int W  = (S < 2*P) ? S : 2*P;
        localparam int NB = (S > 2*P) ? S / (2*P) : 1;

        logic [S*Q-1:0]  lay_q, lay_d;
        logic [W*Q-1:0]  wbeat;
        logic [AW-1:0]   wk;
        logic            wr_hit, clr_hit;

        assign wr_hit  = wr_ok && (bus.w_layer == LW'(l));
        assign clr_hit = busy && (cnt_q == LW'(l));
        assign wk      = bus.w_addr & AW'(NB - 1);
        assign wbeat   = {bus.b_in[P*Q +: (W/2)*Q], bus.b_in[0 +: (W/2)*Q]};

        always_comb begin
            lay_d = lay_q;
            if (clr_hit) begin
                lay_d = '0;
            end else if (wr_hit) begin
                lay_d[wk*(W*Q) +: W*Q] = wbeat;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) lay_q <= '0;
            else     lay_q <= lay_d;
        end

        // Reads tap lay_d so a same-cycle write to overlapping words is bypassed.
        if (S < P) begin : g_narrow
            assign rd_data[l] = {{((P - S)*Q){1'b0}}, lay_d};
        end else begin : g_wide
            localparam int NR = S / P;
            logic [AW-1:0] rk;
            assign rk         = bus.r_addr & AW'(NR - 1);
            assign rd_data[l] = lay_d[rk*(P*Q) +: P*Q];
        end
    end

    always_comb begin
        b_out_d   = '0;
        r_valid_d = bus.r_en;
        if (bus.r_en && !busy) begin
            for (int l = 1; l < LOGN; l++) begin
                if (bus.r_layer == LW'(l)) b_out_d = rd_data[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_out_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            b_out_q   <= b_out_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign bus.busy    = busy;
    assign bus.b_out   = b_out_q;
    assign bus.r_valid = r_valid_q;

endmodule

// File: tb/tb_scan_belief_mem.sv
// Directed bench for scan_belief_mem at default parameters (N=1024, P=128, Q=6).
module tb_scan_belief_mem;

    localparam int P    = 128;
    localparam int Q    = 6;
    localparam int N    = 1024;
    localparam int LOGN = 10;
    localparam int LW   = 4;
    localparam int AW   = 2;
    localparam int PQ   = P*Q;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    scan_belief_mem_if #(.P(P), .Q(Q), .N(N)) bus ();

    scan_belief_mem #(.P(P), .Q(Q), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [PQ-1:0] obs, input logic [PQ-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Word value for logical word index i; differs between every 128-word beat.
    function automatic logic [Q-1:0] pat(input int i, input int seed);
        return Q'((i + 7*(i >> 6) + seed) & 63);
    endfunction

    function automatic logic [PQ-1:0] lanes(input int base, input int cnt, input int seed);
        logic [PQ-1:0] v;
        v = '0;
        for (int j = 0; j < cnt; j++) v[j*Q +: Q] = pat(base + j, seed);
        return v;
    endfunction

    // Unused b_in words carry junk that must never land in storage.
    function automatic logic [2*PQ-1:0] mk_bin(input int lo, input int hi, input int cnt, input int seed);
        logic [2*PQ-1:0] v;
        for (int j = 0; j < P; j++) begin
            v[j*Q +: Q]     = (j < cnt) ? pat(lo + j, seed) : Q'(6'h2A);
            v[(P+j)*Q +: Q] = (j < cnt) ? pat(hi + j, seed) : Q'(6'h15);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int layer, input int addr, input logic [2*PQ-1:0] data);
        bus.w_en    = 1'b1;
        bus.w_layer = LW'(layer);
        bus.w_addr  = AW'(addr);
        bus.b_in    = data;
        tick();
        bus.w_en    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int layer, input int addr, input logic [PQ-1:0] exp);
        bus.r_en    = 1'b1;
        bus.r_layer = LW'(layer);
        bus.r_addr  = AW'(addr);
        tick();
        bus.r_en    = 1'b0;
        chk(tag, bus.b_out, exp);
        chk({tag, "_vld"}, PQ'(bus.r_valid), PQ'(1));
    endtask

    task automatic fill_layer(input int l, input int seed);
        int s, cnt, nb;
        s   = 1 << l;
        cnt = (s/2 < P) ? s/2 : P;
        nb  = (s > 2*P) ? s/(2*P) : 1;
        for (int k = 0; k < nb; k++) wr(l, k, mk_bin(k*2*cnt, k*2*cnt + cnt, cnt, seed));
    endtask

    initial begin
        bus.clr_start = 1'b0;
        bus.w_en      = 1'b0;
        bus.w_layer   = '0;
        bus.w_addr    = '0;
        bus.b_in      = '0;
        bus.r_en      = 1'b0;
        bus.r_layer   = '0;
        bus.r_addr    = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_bout", bus.b_out, '0);
        chk("rst_vld", PQ'(bus.r_valid), '0);
        chk("rst_busy", PQ'(bus.busy), '0);

        for (int l = 1; l < LOGN; l++)
            for (int a = 0; a < 4; a++)
                rd_chk($sformatf("rst_l%0d_a%0d", l, a), l, a, '0);

        // Layer 3: lanes 0..7 = 1..8.
        wr(3, 0, mk_bin(0, 4, 4, 1));
        chk("idle_vld", PQ'(bus.r_valid), '0);
        chk("idle_bout", bus.b_out, '0);
        rd_chk("l3", 3, 0, lanes(0, 8, 1));
        rd_chk("l3_addrmask", 3, 3, lanes(0, 8, 1));

        // Layer 9: two write beats, four read beats.
        wr(9, 0, mk_bin(0, 128, 128, 9));
        wr(9, 1, mk_bin(256, 384, 128, 9));
        for (int r = 0; r < 4; r++)
            rd_chk($sformatf("l9_r%0d", r), 9, r, lanes(128*r, 128, 9));

        // Layer 8 bypass: same-cycle write and read show the new words.
        wr(8, 0, mk_bin(0, 128, 128, 10));
        bus.w_en    = 1'b1;
        bus.w_layer = LW'(8);
        bus.w_addr  = '0;
        bus.b_in    = mk_bin(0, 128, 128, 33);
        rd_chk("l8_bypass", 8, 0, lanes(0, 128, 33));
        bus.w_en    = 1'b0;
        rd_chk("l8_r1", 8, 1, lanes(128, 128, 33));

        for (int l = 1; l < LOGN; l++) fill_layer(l, l);
        rd_chk("fill_l1", 1, 0, lanes(0, 2, 1));
        rd_chk("fill_l7", 7, 0, lanes(0, 128, 7));
        rd_chk("fill_l9_r3", 9, 3, lanes(384, 128, 9));

        // Clear: busy for exactly 9 cycles; writes dropped, reads zero.
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("clr_busy%0d", i), PQ'(bus.busy), PQ'(1));
            if (i == 4) begin
                chk("clr_rd_bout", bus.b_out, '0);
                chk("clr_rd_vld", PQ'(bus.r_valid), PQ'(1));
                bus.clr_start = 1'b1;
            end
            if (i == 2) begin
                bus.w_en = 1'b1; bus.w_layer = LW'(2); bus.w_addr = '0;
                bus.b_in = mk_bin(0, 2, 2, 50);
            end
            if (i == 5) begin
                bus.w_en = 1'b1; bus.w_layer = LW'(1); bus.w_addr = '0;
                bus.b_in = mk_bin(0, 1, 1, 51);
            end
            if (i == 3) begin
                bus.r_en = 1'b1; bus.r_layer = LW'(9); bus.r_addr = '0;
            end
            tick();
            bus.w_en = 1'b0;
            bus.r_en = 1'b0;
            bus.clr_start = 1'b0;
        end
        chk("clr_done", PQ'(bus.busy), '0);
        for (int l = 1; l < LOGN; l++)
            for (int a = 0; a < 4; a++)
                rd_chk($sformatf("clr_l%0d_a%0d", l, a), l, a, '0);

        // Invalid layers: writes dropped, read returns zero with valid.
        wr(5, 0, mk_bin(0, 16, 16, 20));
        wr(0, 0, '1);
        wr(15, 0, '1);
        rd_chk("bad_rd12", 12, 0, '0);
        for (int l = 1; l < LOGN; l++)
            rd_chk($sformatf("bad_l%0d", l), l, 0, (l == 5) ? lanes(0, 32, 20) : '0);

        // clr_start under reset is ignored; reset aborts a running clear.
        rst = 1'b1; bus.clr_start = 1'b1;
        tick();
        rst = 1'b0; bus.clr_start = 1'b0;
        chk("rst_clr_ign", PQ'(bus.busy), '0);
        rd_chk("rst_zeroed_l5", 5, 0, '0);
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        tick();
        chk("clr_run", PQ'(bus.busy), PQ'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("clr_abort", PQ'(bus.busy), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
